// File: rtl/alu_reservation_station.sv
// alu_reservation_station: 16-entry reservation station between dispatch and
// the integer ALU. Captures CDB broadcasts, issues the lowest-index ready entry.
module alu_reservation_station #(
    parameter int unsigned ROB_W = 4,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             disp_valid_in,
    input  logic [OP_W-1:0]  disp_op_in,
    input  logic [XLEN-1:0]  disp_Vj_in,
    input  logic [XLEN-1:0]  disp_Vk_in,
    input  logic [ROB_W-1:0] disp_Qj_in,
    input  logic [ROB_W-1:0] disp_Qk_in,
    input  logic [ROB_W-1:0] disp_dest_in,
    input  logic             cdb_valid_in,
    input  logic [ROB_W-1:0] cdb_tag_in,
    input  logic [XLEN-1:0]  cdb_value_in,
    output logic             full_out,
    output logic             alu_valid_out,
    output logic [OP_W-1:0]  alu_op_out,
    output logic [XLEN-1:0]  alu_Vj_out,
    output logic [XLEN-1:0]  alu_Vk_out,
    output logic [ROB_W-1:0] alu_dest_out
);

    localparam int unsigned NENT  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic [ROB_W-1:0] dest;
    } entry_t;

    entry_t           ent_q [NENT];
    entry_t           ent_d [NENT];
    logic [NENT-1:0]  busy_q, busy_d;

    logic             alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [XLEN-1:0]  alu_vj_q, alu_vj_d;
    logic [XLEN-1:0]  alu_vk_q, alu_vk_d;
    logic [ROB_W-1:0] alu_dest_q, alu_dest_d;

    logic [NENT-1:0]  ready_c;
    logic             issue_any_c;
    logic [IDX_W-1:0] issue_idx_c;
    logic             vac_any_c;
    logic [IDX_W-1:0] vac_idx_c;
    logic [CNT_W-1:0] free_cnt_c;
    logic             cdb_live_c;
    entry_t           new_ent_c;

    // Index of the lowest set bit (0 when none set; qualify with |v).
    function automatic logic [IDX_W-1:0] first_one(input logic [NENT-1:0] v);
        logic [IDX_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (v[i] && !found) begin
                r     = IDX_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Number of set bits.
    function automatic logic [CNT_W-1:0] count_ones(input logic [NENT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NENT; i++) begin
            if (v[i]) c = c + CNT_W'(1);
        end
        return c;
    endfunction

    // Ready vector, selection helpers and dispatch-side full indication.
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            ready_c[i] = busy_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
        end
        issue_any_c = |ready_c;
        issue_idx_c = first_one(ready_c);
        vac_any_c   = ~&busy_q;
        vac_idx_c   = first_one(~busy_q);
        free_cnt_c  = count_ones(~busy_q);
        full_out    = (free_cnt_c == '0) ||
                      ((free_cnt_c == CNT_W'(1)) && disp_valid_in);
        cdb_live_c  = cdb_valid_in && (cdb_tag_in != '0);
    end

    // Incoming entry with same-cycle CDB bypass on each operand.
    always_comb begin
        new_ent_c.op   = disp_op_in;
        new_ent_c.vj   = disp_Vj_in;
        new_ent_c.vk   = disp_Vk_in;
        new_ent_c.qj   = disp_Qj_in;
        new_ent_c.qk   = disp_Qk_in;
        new_ent_c.dest = disp_dest_in;
        if (cdb_live_c && (disp_Qj_in == cdb_tag_in)) begin
            new_ent_c.vj = cdb_value_in;
            new_ent_c.qj = '0;
        end
        if (cdb_live_c && (disp_Qk_in == cdb_tag_in)) begin
            new_ent_c.vk = cdb_value_in;
            new_ent_c.qk = '0;
        end
    end

    // Next state: flush, stall, or wakeup + issue + dispatch.
    always_comb begin
        ent_d       = ent_q;
        busy_d      = busy_q;
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_vj_d    = alu_vj_q;
        alu_vk_d    = alu_vk_q;
        alu_dest_d  = alu_dest_q;

        if (flush_in) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
        end else if (rdy_in) begin
            alu_valid_d = 1'b0;

            for (int i = 0; i < NENT; i++) begin
                if (busy_q[i] && cdb_live_c && (ent_q[i].qj == cdb_tag_in)) begin
                    ent_d[i].vj = cdb_value_in;
                    ent_d[i].qj = '0;
                end
                if (busy_q[i] && cdb_live_c && (ent_q[i].qk == cdb_tag_in)) begin
                    ent_d[i].vk = cdb_value_in;
                    ent_d[i].qk = '0;
                end
            end

            if (issue_any_c) begin
                alu_valid_d         = 1'b1;
                alu_op_d            = ent_q[issue_idx_c].op;
                alu_vj_d            = ent_q[issue_idx_c].vj;
                alu_vk_d            = ent_q[issue_idx_c].vk;
                alu_dest_d          = ent_q[issue_idx_c].dest;
                busy_d[issue_idx_c] = 1'b0;
            end

            // Vacancy comes from pre-edge busy, so it never aliases the issued slot.
            if (disp_valid_in && vac_any_c) begin
                ent_d[vac_idx_c]  = new_ent_c;
                busy_d[vac_idx_c] = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_vj_q    <= '0;
            alu_vk_q    <= '0;
            alu_dest_q  <= '0;
            for (int i = 0; i < NENT; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_vj_q    <= alu_vj_d;
            alu_vk_q    <= alu_vk_d;
            alu_dest_q  <= alu_dest_d;
            for (int i = 0; i < NENT; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign alu_valid_out = alu_valid_q;
    assign alu_op_out    = alu_op_q;
    assign alu_Vj_out    = alu_vj_q;
    assign alu_Vk_out    = alu_vk_q;
    assign alu_dest_out  = alu_dest_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_alu_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, disp_valid_in;
    logic [4:0]  disp_op_in;
    logic [31:0] disp_Vj_in, disp_Vk_in;
    logic [3:0]  disp_Qj_in, disp_Qk_in, disp_dest_in;
    logic        cdb_valid_in;
    logic [3:0]  cdb_tag_in;
    logic [31:0] cdb_value_in;
    logic        full_out, alu_valid_out;
    logic [4:0]  alu_op_out;
    logic [31:0] alu_Vj_out, alu_Vk_out;
    logic [3:0]  alu_dest_out;

    alu_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
        .disp_Vj_in(disp_Vj_in), .disp_Vk_in(disp_Vk_in),
        .disp_Qj_in(disp_Qj_in), .disp_Qk_in(disp_Qk_in), .disp_dest_in(disp_dest_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
        .full_out(full_out), .alu_valid_out(alu_valid_out), .alu_op_out(alu_op_out),
        .alu_Vj_out(alu_Vj_out), .alu_Vk_out(alu_Vk_out), .alu_dest_out(alu_dest_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        dv;
        logic [4:0]  op;
        logic [31:0] vj, vk;
        logic [3:0]  qj, qk, dest;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        fl;
        logic        rdy;
    } in_t;

    typedef struct {
        in_t         in;
        logic        ev;
        logic [31:0] evj, evk;
        logic [3:0]  edest;
        logic        efull;
    } vec_t;

    // Behavioural model: a table of slots plus the last issued instruction.
    bit          m_busy [16];
    logic [4:0]  m_op   [16];
    logic [31:0] m_vj   [16], m_vk [16];
    logic [3:0]  m_qj   [16], m_qk [16], m_dest [16];
    logic        m_valid;
    logic [4:0]  m_op_o;
    logic [31:0] m_vj_o, m_vk_o;
    logic [3:0]  m_dest_o;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic f;
    vec_t tbl [10];
    in_t  s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t r;
        r.dv = 0; r.op = 0; r.vj = 0; r.vk = 0; r.qj = 0; r.qk = 0; r.dest = 0;
        r.cv = 0; r.ct = 0; r.cval = 0; r.fl = 0; r.rdy = 1;
        return r;
    endfunction

    function automatic in_t disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
        in_t r;
        r = idle();
        r.dv = 1; r.op = op; r.vj = vj; r.vk = vk; r.qj = qj; r.qk = qk; r.dest = dest;
        return r;
    endfunction

    function automatic in_t bcast(input logic [3:0] tag, input logic [31:0] val);
        in_t r;
        r = idle();
        r.cv = 1; r.ct = tag; r.cval = val;
        return r;
    endfunction

    function automatic vec_t mkv(input in_t in, input logic ev, input logic [31:0] evj,
                                 input logic [31:0] evk, input logic [3:0] edest);
        vec_t v;
        v.in = in; v.ev = ev; v.evj = evj; v.evk = evk; v.edest = edest; v.efull = 1'b0;
        return v;
    endfunction

    task automatic apply(input in_t x);
        disp_valid_in = x.dv; disp_op_in = x.op; disp_Vj_in = x.vj; disp_Vk_in = x.vk;
        disp_Qj_in = x.qj; disp_Qk_in = x.qk; disp_dest_in = x.dest;
        cdb_valid_in = x.cv; cdb_tag_in = x.ct; cdb_value_in = x.cval;
        flush_in = x.fl; rdy_in = x.rdy;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 0;
        m_valid = 0; m_op_o = 0; m_vj_o = 0; m_vk_o = 0; m_dest_o = 0;
    endtask

    function automatic logic model_full(input logic dv);
        int free_n;
        free_n = 0;
        for (int i = 0; i < 16; i++) if (!m_busy[i]) free_n++;
        return (free_n == 0) || (free_n == 1 && dv);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int ri, vi;
        ri = -1; vi = -1;
        if (flush_in) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 0;
            m_valid = 0;
        end else if (rdy_in) begin
            for (int i = 0; i < 16; i++)
                if (ri < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) ri = i;
            for (int i = 0; i < 16; i++)
                if (vi < 0 && !m_busy[i]) vi = i;
            m_valid = (ri >= 0);
            if (ri >= 0) begin
                m_op_o = m_op[ri]; m_vj_o = m_vj[ri]; m_vk_o = m_vk[ri]; m_dest_o = m_dest[ri];
                m_busy[ri] = 0;
            end
            if (cdb_valid_in && cdb_tag_in != 0) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_busy[i] && m_qj[i] == cdb_tag_in) begin m_vj[i] = cdb_value_in; m_qj[i] = 0; end
                    if (m_busy[i] && m_qk[i] == cdb_tag_in) begin m_vk[i] = cdb_value_in; m_qk[i] = 0; end
                end
            end
            if (disp_valid_in && vi >= 0) begin
                m_busy[vi] = 1; m_op[vi] = disp_op_in; m_dest[vi] = disp_dest_in;
                m_vj[vi] = disp_Vj_in; m_qj[vi] = disp_Qj_in;
                m_vk[vi] = disp_Vk_in; m_qk[vi] = disp_Qk_in;
                if (cdb_valid_in && cdb_tag_in != 0 && disp_Qj_in == cdb_tag_in) begin
                    m_vj[vi] = cdb_value_in; m_qj[vi] = 0;
                end
                if (cdb_valid_in && cdb_tag_in != 0 && disp_Qk_in == cdb_tag_in) begin
                    m_vk[vi] = cdb_value_in; m_qk[vi] = 0;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check full_out, clock, check registered outputs.
    task automatic step(input in_t x, output logic full_s);
        apply(x);
        #1;
        full_s = full_out;
        chk("full_out", 32'(full_out), 32'(model_full(x.dv)));
        @(posedge clk_in);
        model_step();
        #1;
        chk("alu_valid", 32'(alu_valid_out), 32'(m_valid));
        chk("alu_op", 32'(alu_op_out), 32'(m_op_o));
        chk("alu_vj", alu_Vj_out, m_vj_o);
        chk("alu_vk", alu_Vk_out, m_vk_o);
        chk("alu_dest", 32'(alu_dest_out), 32'(m_dest_o));
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        apply(idle());
        @(posedge clk_in);
        @(posedge clk_in);
        model_reset();
        #1;
        chk("rst_valid", 32'(alu_valid_out), 32'd0);
        chk("rst_op", 32'(alu_op_out), 32'd0);
        chk("rst_vj", alu_Vj_out, 32'd0);
        chk("rst_vk", alu_Vk_out, 32'd0);
        chk("rst_dest", 32'(alu_dest_out), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        apply(idle());
        @(negedge clk_in);

        // Directed table: ready issue, CDB wakeup, dispatch-cycle bypass.
        do_reset();
        tbl[0] = mkv(disp(5'd3, 32'd5, 32'd7, 4'd0, 4'd0, 4'd2), 0, 0, 0, 0);
        tbl[1] = mkv(idle(), 1, 32'd5, 32'd7, 4'd2);
        tbl[2] = mkv(idle(), 0, 0, 0, 0);
        tbl[3] = mkv(disp(5'd1, 32'd0, 32'd3, 4'd4, 4'd0, 4'd9), 0, 0, 0, 0);
        tbl[4] = mkv(idle(), 0, 0, 0, 0);
        tbl[5] = mkv(bcast(4'd4, 32'h10), 0, 0, 0, 0);
        tbl[6] = mkv(idle(), 1, 32'h10, 32'd3, 4'd9);
        s = disp(5'd2, 32'd0, 32'd0, 4'd6, 4'd0, 4'd11);
        s.cv = 1; s.ct = 4'd6; s.cval = 32'd9;
        tbl[7] = mkv(s, 0, 0, 0, 0);
        tbl[8] = mkv(idle(), 1, 32'd9, 32'd0, 4'd11);
        tbl[9] = mkv(idle(), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in, f);
            chk($sformatf("tbl%0d_full", i), 32'(f), 32'(tbl[i].efull));
            chk($sformatf("tbl%0d_valid", i), 32'(alu_valid_out), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_vj", i), alu_Vj_out, tbl[i].evj);
                chk($sformatf("tbl%0d_vk", i), alu_Vk_out, tbl[i].evk);
                chk($sformatf("tbl%0d_dest", i), 32'(alu_dest_out), 32'(tbl[i].edest));
            end
        end

        // Fill all 16 slots waiting on tag 1, overflow attempt, then ordered drain.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            step(disp(5'(k), 32'(k), 32'd0, 4'd1, 4'd0, 4'(k)), f);
            chk("fill_full_low", 32'(f), 32'd0);
        end
        step(disp(5'd15, 32'd15, 32'd0, 4'd1, 4'd0, 4'd15), f);
        chk("full_at_16th", 32'(f), 32'd1);
        step(disp(5'd31, 32'hdead, 32'd0, 4'd0, 4'd0, 4'd0), f);
        chk("full_at_17th", 32'(f), 32'd1);
        chk("no_issue_17th", 32'(alu_valid_out), 32'd0);
        step(bcast(4'd1, 32'haa), f);
        chk("no_same_cycle_issue", 32'(alu_valid_out), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step(idle(), f);
            chk($sformatf("drain%0d_valid", k), 32'(alu_valid_out), 32'd1);
            chk($sformatf("drain%0d_dest", k), 32'(alu_dest_out), 32'(k));
            chk($sformatf("drain%0d_op", k), 32'(alu_op_out), 32'(k));
            chk($sformatf("drain%0d_vj", k), alu_Vj_out, 32'haa);
        end
        step(idle(), f);
        chk("drain_done", 32'(alu_valid_out), 32'd0);

        // Two entries wake on the same tag: lower index issues first.
        do_reset();
        for (int k = 0; k < 8; k++)
            step(disp(5'(k), 32'd0, 32'd0, (k == 3 || k == 7) ? 4'd5 : 4'd9, 4'd0, 4'(k)), f);
        step(bcast(4'd5, 32'h55), f);
        chk("tie_wait", 32'(alu_valid_out), 32'd0);
        step(idle(), f);
        chk("tie_first_valid", 32'(alu_valid_out), 32'd1);
        chk("tie_first_dest", 32'(alu_dest_out), 32'd3);
        step(idle(), f);
        chk("tie_second_valid", 32'(alu_valid_out), 32'd1);
        chk("tie_second_dest", 32'(alu_dest_out), 32'd7);
        step(idle(), f);
        chk("tie_done", 32'(alu_valid_out), 32'd0);

        // Flush with 8 busy entries and a simultaneous dispatch.
        step(disp(5'd8, 32'd0, 32'd0, 4'd9, 4'd0, 4'd8), f);
        step(disp(5'd9, 32'd0, 32'd0, 4'd9, 4'd0, 4'd9), f);
        s = disp(5'd12, 32'd1, 32'd2, 4'd0, 4'd0, 4'd12);
        s.fl = 1;
        step(s, f);
        chk("flush_valid", 32'(alu_valid_out), 32'd0);
        step(idle(), f);
        chk("flush_drop_disp", 32'(alu_valid_out), 32'd0);
        step(bcast(4'd9, 32'd1), f);
        step(idle(), f);
        chk("flush_cleared", 32'(alu_valid_out), 32'd0);

        // rdy_in low for 3 cycles: dispatch and CDB dropped, state holds.
        for (int k = 0; k < 8; k++)
            step(disp(5'(k), 32'd0, 32'd0, 4'd9, 4'd0, 4'(k)), f);
        for (int k = 0; k < 3; k++) begin
            s = disp(5'd14, 32'd1, 32'd1, 4'd0, 4'd0, 4'd14);
            s.cv = 1; s.ct = 4'd9; s.cval = 32'd3; s.rdy = 0;
            step(s, f);
            chk("stall_valid", 32'(alu_valid_out), 32'd0);
        end
        step(idle(), f);
        chk("stall_dropped", 32'(alu_valid_out), 32'd0);
        step(bcast(4'd9, 32'd7), f);
        for (int k = 0; k < 8; k++) begin
            step(idle(), f);
            chk("stall_drain_valid", 32'(alu_valid_out), 32'd1);
            chk("stall_drain_dest", 32'(alu_dest_out), 32'(k));
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.dv   = ($urandom % 3) != 0;
            s.op   = 5'($urandom);
            s.vj   = $urandom;
            s.vk   = $urandom;
            s.qj   = ($urandom % 2) ? 4'($urandom % 8) : 4'd0;
            s.qk   = ($urandom % 2) ? 4'($urandom % 8) : 4'd0;
            s.dest = 4'($urandom);
            s.cv   = ($urandom % 2) != 0;
            s.ct   = 4'($urandom % 8);
            s.cval = $urandom;
            s.fl   = ($urandom % 64) == 0;
            s.rdy  = ($urandom % 8) != 0;
            step(s, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- 16-entry reservation station for integer ALU instructions; sits between dispatch and the ALU.
- Accepts one decoded instruction per cycle and captures operand values from the common data bus (CDB) as they are broadcast.
- Issues the lowest-index entry whose operands are all ready, one per cycle, to the ALU.
- Entry selection uses the team's first-ready, first-vacant and vacancy-count helpers.

Parameters:
ROB_W, 4, ROB tag width; tag 0 means "no dependency / value present"
OP_W, 5, ALU opcode width
XLEN, 32, operand width

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global enable; when low all state holds and no issue occurs
flush_in  input  1  mispredict flush; clears all entries
disp_valid_in  input  1  dispatch request
disp_op_in  input  OP_W  opcode
disp_Vj_in  input  XLEN  operand j value (meaningful when Qj=0)
disp_Vk_in  input  XLEN  operand k value (meaningful when Qk=0)
disp_Qj_in  input  ROB_W  producer tag of j, 0 if ready
disp_Qk_in  input  ROB_W  producer tag of k, 0 if ready
disp_dest_in  input  ROB_W  destination ROB tag
cdb_valid_in  input  1  CDB broadcast valid
cdb_tag_in  input  ROB_W  broadcast ROB tag
cdb_value_in  input  XLEN  broadcast value
full_out  output  1  dispatch must not be sent next cycle
alu_valid_out  output  1  issue valid (registered)
alu_op_out  output  OP_W  issued opcode
alu_Vj_out  output  XLEN  issued operand j
alu_Vk_out  output  XLEN  issued operand k
alu_dest_out  output  ROB_W  issued destination tag

Behaviour:
- Reset (rst_in=1 at clock edge): all busy bits 0. alu_valid_out, alu_op_out, alu_Vj_out, alu_Vk_out and alu_dest_out all 0. full_out goes to 0 combinationally.
- Precedence: rst_in > flush_in > rdy_in=0 > normal operation.
- Flush: all busy bits clear and alu_valid_out=0 next cycle. Dispatch and CDB inputs in the flush cycle are ignored.
- rdy_in=0: entries and outputs hold. Dispatch and CDB inputs in that cycle are dropped.
- Per-entry state: busy, op, Vj, Vk, Qj, Qk, dest.
- Dispatch:
  - When disp_valid_in=1 and a vacancy exists, write the lowest-index vacant entry and set busy.
  - Dispatch with no vacancy is ignored; upstream must honour full_out.
- Dispatch-cycle bypass: if cdb_valid_in=1 and disp_Qj_in equals cdb_tag_in and is nonzero, store Vj=cdb_value_in and Qj=0. The same rule applies to k independently.
- Wakeup: each busy entry whose Qj (or Qk) equals cdb_tag_in, nonzero, with cdb_valid_in=1 captures the value and clears that Q at the edge.
- Ready: busy && Qj==0 && Qk==0, evaluated on registered state only. An entry woken at edge t is issuable in cycle t+1 at the earliest, never the same cycle.
- Issue:
  - Each enabled cycle, if any entry is ready, register the lowest-index ready entry onto the alu_* outputs, assert alu_valid_out for one cycle, and clear that entry's busy at the same edge.
  - Otherwise alu_valid_out=0; the data outputs hold their previous values.
- Issue and dispatch in the same cycle: the freed slot is not reusable that cycle. The vacancy search uses pre-edge busy.
- full_out is combinational: (free count == 0) || (free count == 1 && disp_valid_in). The one-vacancy term covers the one-cycle dispatch latency. Issue in the current cycle is not credited.
- Throughput: 1 dispatch + 1 issue per cycle.
- Latency: dispatch with both operands ready at edge t leads to alu_valid_out at edge t+1.

Test Plan:
- Reset, then dispatch op=3, Qj=Qk=0, Vj=5, Vk=7, dest=2 → next cycle alu_valid_out=1, Vj=5, Vk=7, dest=2; following cycle alu_valid_out=0.
- Dispatch Qj=4, Qk=0; two cycles later CDB tag=4 value=0x10 → alu_valid_out one cycle after the broadcast, with Vj=0x10; no issue before that.
- Dispatch Qj=6 while the CDB carries tag=6 value=9 in the same cycle → entry captures 9 and issues the next cycle.
- Fill 15 entries with Qj=1, then assert disp_valid_in → full_out=1 that cycle. The 16th dispatch is accepted. A 17th attempt is ignored with no entry overwritten. CDB tag=1 then drains all 16 entries in index order over 16 cycles.
- Entries 3 and 7 both waiting on tag=5; broadcast tag=5 → entry 3 issues first, entry 7 on the next cycle.
- 8 busy entries, then flush_in=1 together with a dispatch → next cycle all vacant, full_out=0, alu_valid_out=0; dispatch dropped. Repeat with rdy_in=0 for 3 cycles → no state change.
